inst_fetch_mem: RTL
===================

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter DATA_W SHALL default to 32 and set the instruction word width in bits.
REQ-003 Parameter ADDR_W SHALL default to 32 and set the byte address width.
REQ-004 Parameter DEPTH SHALL default to 256 and set the number of words (power of two, at least 4).
REQ-005 Port clk SHALL be an input, 1 bit wide: rising-edge clock.
REQ-006 Port rst_n SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-007 Port reqValid SHALL be an input, 1 bit wide: fetch request valid.
REQ-008 Port reqReady SHALL be an output, 1 bit wide: block can accept a request.
REQ-009 Port reqAddr SHALL be an input, ADDR_W bits wide: byte address of the fetch.
REQ-010 Port rspValid SHALL be an output, 1 bit wide: response valid.
REQ-011 Port rspReady SHALL be an input, 1 bit wide: consumer accepts the response.
REQ-012 Port rspData SHALL be an output, DATA_W bits wide: fetched instruction.
REQ-013 Port rspErr SHALL be an output, 1 bit wide: fetch was misaligned or out of range.

Function
REQ-014 A request SHALL be accepted on a rising edge where reqValid and reqReady are both 1.
REQ-015 The word index SHALL be reqAddr >> log2(DATA_W/8).
REQ-016 Latency SHALL be 1 cycle: a request accepted at edge N gives rspValid=1 after edge N, provided the response buffer was empty.
REQ-017 Responses SHALL be buffered in a 2-entry in-order FIFO with occupancy states EMPTY, ONE and FULL.
REQ-018 reqReady SHALL be a function of registered occupancy only: 1 in EMPTY or ONE, 0 in FULL. There is no same-cycle pass-through when FULL.
REQ-019 A response SHALL pop on an edge where rspValid and rspReady are both 1.
REQ-020 Occupancy transitions SHALL be: push only increments; pop only decrements; push and pop together hold the state.
REQ-021 rspValid SHALL equal (occupancy != EMPTY). rspData and rspErr SHALL show the head entry and stay stable while rspValid=1 and rspReady=0.
REQ-022 If the low address bits are non-zero (misaligned), the response SHALL have rspErr=1 and rspData=0.
REQ-023 If the word index is greater than or equal to DEPTH, the response SHALL have rspErr=1 and rspData=0. The index SHALL NOT wrap.
REQ-024 All DEPTH words SHALL be zero at time 0, including the last word.
REQ-025 rspData and rspErr SHALL be 0 whenever rspValid=0.

Reset
REQ-026 While rst_n=0, occupancy SHALL be EMPTY, rspValid=0, rspData=0, rspErr=0 and reqReady=0.
REQ-027 reqReady SHALL rise to 1 on the first clk edge after rst_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all buffered responses immediately.
REQ-029 Reset SHALL NOT alter memory contents.

Configuration
REQ-030 With INST_FETCH_MEM_LOAD_PORT_EN defined, the block SHALL add inputs ldEn (1 bit), ldAddr (log2(DEPTH) bits, word index) and ldData (DATA_W bits).
REQ-031 With the macro defined, the word SHALL be written on a clk edge with ldEn=1.
REQ-032 With the macro defined, a fetch of the same word on the same edge SHALL return the old contents.
REQ-033 Loads SHALL proceed even while rst_n=0.
REQ-034 Without the macro, the load ports SHALL be absent and the memory SHALL be read-only after initialisation.

Structure
REQ-035 Package inst_fetch_mem_pkg SHALL hold the default DATA_W, ADDR_W and DEPTH constants and the occupancy state encoding.
REQ-036 The 2-entry response buffer SHALL be a sub-module named inst_rsp_fifo, parametrised by DATA_W+1.

Verification
REQ-037 The bench SHALL cover this scenario: with the load port, write 0xDEADBEEF to word 5, then fetch address 0x14 with rspReady=1 -> rspValid after 1 cycle, rspData=0xDEADBEEF, rspErr=0.
REQ-038 The bench SHALL cover this scenario: fetch 0x16 -> rspErr=1, rspData=0.
REQ-039 The bench SHALL cover this scenario: with DEPTH=256, fetch 0x400 -> rspErr=1, rspData=0 (word 0 is not returned).
REQ-040 The bench SHALL cover this scenario: hold rspReady=0 and issue 3 back-to-back requests -> first two accepted, reqReady=0 on the third; release rspReady -> responses in order, third accepted the cycle after the first pop.
REQ-041 The bench SHALL cover this scenario: assert rst_n=0 with FIFO FULL -> rspValid=0 immediately; a fetch after release returns the pre-reset memory data.
REQ-042 The bench SHALL cover this scenario: fetch 0x3FC after power-up -> rspData=0, rspErr=0.

Source files
------------

// File: rtl/inst_fetch_mem_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : inst_fetch_mem_pkg
// Purpose  : Default geometry of the instruction fetch memory and the
//            occupancy encoding of its 2-entry response buffer.
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_mem_pkg;

  localparam int c_DEF_DATA_W = 32;
  localparam int c_DEF_ADDR_W = 32;
  localparam int c_DEF_DEPTH  = 256;

  // Response buffer occupancy
  localparam logic [1:0] c_OCC_EMPTY = 2'd0;
  localparam logic [1:0] c_OCC_ONE   = 2'd1;
  localparam logic [1:0] c_OCC_FULL  = 2'd2;

  // Next occupancy: push alone counts up, pop alone counts down, both hold.
  // The unused encoding falls back to EMPTY.
  function automatic logic [1:0] occNext(input logic [1:0] occ,
                                         input logic       push,
                                         input logic       pop);
    logic [1:0] nxt;
    nxt = occ;
    case (occ)
      c_OCC_EMPTY: if (push) nxt = c_OCC_ONE;
      c_OCC_ONE: begin
        if (push && !pop)      nxt = c_OCC_FULL;
        else if (!push && pop) nxt = c_OCC_EMPTY;
      end
      c_OCC_FULL:  if (pop && !push) nxt = c_OCC_ONE;
      default:     nxt = c_OCC_EMPTY;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_rsp_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : inst_rsp_fifo
// Purpose  : 2-entry in-order response buffer. Ready depends only on the
//            registered occupancy (no pass-through when FULL); the output
//            reads zero whenever the buffer is empty.
// Revision : 1.0 - initial release
// ============================================================================
module inst_rsp_fifo
  import inst_fetch_mem_pkg::*;
#(
  parameter int WIDTH = c_DEF_DATA_W + 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pushValid,
  input  logic [WIDTH-1:0] pushData,
  output logic             pushReady,
  output logic             popValid,
  output logic [WIDTH-1:0] popData,
  input  logic             popReady
);

  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_push;
  logic             w_pop;

  assign pushReady = (r_occ != c_OCC_FULL);
  assign popValid  = (r_occ != c_OCC_EMPTY);
  assign popData   = popValid ? r_head : {WIDTH{1'b0}};

  assign w_push = pushValid && pushReady;
  assign w_pop  = popValid && popReady;

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occ <= c_OCC_EMPTY;
    else        r_occ <= occNext(r_occ, w_push, w_pop);
  end

  // Entry storage: head is always the oldest response, tail the second one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= {WIDTH{1'b0}};
      r_tail <= {WIDTH{1'b0}};
    end else begin
      case (r_occ)
        c_OCC_EMPTY: begin
          if (w_push) r_head <= pushData;
        end
        c_OCC_ONE: begin
          if (w_push && w_pop) r_head <= pushData;
          else if (w_push)     r_tail <= pushData;
        end
        c_OCC_FULL: begin
          if (w_pop) r_head <= r_tail;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_mem.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : inst_fetch_mem
// Purpose  : Instruction fetch memory with a valid/ready request channel and
//            a 1-cycle-latency response channel buffered by a 2-entry FIFO.
//            Misaligned or out-of-range fetches return rspErr=1, rspData=0.
//            Build option: INST_FETCH_MEM_LOAD_PORT_EN adds a word load port
//            (ldEn/ldAddr/ldData); without it the memory is all-zero ROM.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_mem
  import inst_fetch_mem_pkg::*;
#(
  parameter int DATA_W = c_DEF_DATA_W,
  parameter int ADDR_W = c_DEF_ADDR_W,
  parameter int DEPTH  = c_DEF_DEPTH
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [ADDR_W-1:0]        reqAddr,
  output logic                     rspValid,
  input  logic                     rspReady,
  output logic [DATA_W-1:0]        rspData,
  output logic                     rspErr
`ifdef INST_FETCH_MEM_LOAD_PORT_EN
  ,
  input  logic                     ldEn,
  input  logic [$clog2(DEPTH)-1:0] ldAddr,
  input  logic [DATA_W-1:0]        ldData
`endif
);

  localparam int c_OFF_W = $clog2(DATA_W / 8);
  localparam int c_IDX_W = $clog2(DEPTH);

  logic              r_rdyEn;
  logic              w_fifoRdy;
  logic              w_accept;
  logic [ADDR_W-1:0] w_wordIdx;
  logic              w_misal;
  logic              w_oor;
  logic              w_err;
  logic [DATA_W-1:0] w_rdData;
  logic [DATA_W:0]   w_pushEntry;
  logic [DATA_W:0]   w_popEntry;

  // Hold off requests until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdyEn <= 1'b0;
    else        r_rdyEn <= 1'b1;
  end

  assign reqReady = r_rdyEn && w_fifoRdy;
  assign w_accept = reqValid && reqReady;

  // Full-width word index so that indices beyond DEPTH are caught, not wrapped
  assign w_wordIdx = reqAddr >> c_OFF_W;
  assign w_oor     = (w_wordIdx >= ADDR_W'(DEPTH));

  generate
    if (c_OFF_W > 0) begin : g_alignChk
      assign w_misal = |reqAddr[c_OFF_W-1:0];
    end else begin : g_noAlignChk
      assign w_misal = 1'b0;
    end
  endgenerate

  assign w_err = w_misal || w_oor;

`ifdef INST_FETCH_MEM_LOAD_PORT_EN
  logic [DATA_W-1:0]  r_mem [DEPTH] = '{default: '0};
  logic [c_IDX_W-1:0] w_memIdx;

  assign w_memIdx = w_wordIdx[c_IDX_W-1:0];
  // Read is combinational ahead of the edge, so a same-edge load yields old data
  assign w_rdData = r_mem[w_memIdx];

  // Word load port; not reset, so contents survive rst_n and loads run during it
  always_ff @(posedge clk) begin
    if (ldEn) r_mem[ldAddr] <= ldData;
  end
`else
  // No way to write the array, so every word keeps its power-up value of zero
  assign w_rdData = {DATA_W{1'b0}};
`endif

  assign w_pushEntry = {w_err, (w_err ? {DATA_W{1'b0}} : w_rdData)};

  inst_rsp_fifo #(
    .WIDTH (DATA_W + 1)
  ) u_rspFifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .pushValid (w_accept),
    .pushData  (w_pushEntry),
    .pushReady (w_fifoRdy),
    .popValid  (rspValid),
    .popData   (w_popEntry),
    .popReady  (rspReady)
  );

  assign rspErr  = w_popEntry[DATA_W];
  assign rspData = w_popEntry[DATA_W-1:0];

endmodule
`default_nettype wire
